// File: rtl/lifo_pkg.sv
// Shared types for the LIFO arbiter: default data width, operation codes
// and the response-pipeline stage record.
package lifo_pkg;

    localparam int LIFO_DATA_W = 16;
    localparam int ID_W_MAX    = 3;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_e;

    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
        op_e                 op;
        logic                err;
    } rsp_stage_t;

endpackage

// File: rtl/lifo_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or after
// the pointer; the pointer moves past the winner when advance is high.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] rr_ptr;

    always_comb begin
        logic        found;
        int unsigned idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = 32'(rr_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one LIFO stack among NUM_REQ requesters: at most one push or pop per
// cycle, illegal operations rejected, one in-order response per grant.
module lifo_arbiter
    import lifo_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = LIFO_DATA_W,
    parameter int DEPTH   = 8,
    parameter int RD_LAT  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_pop,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic                          rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic                          rsp_err,
    output logic [DATA_W-1:0]             rsp_data,
    output logic [DATA_W-1:0]             stk_in,
    output logic                          stk_wn,
    output logic                          stk_rn,
    input  logic [DATA_W-1:0]             stk_out,
    input  logic                          stk_full,
    input  logic                          stk_empty,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [NUM_REQ-1:0] grant_raw;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic               gnt_pop;
    logic [DATA_W-1:0]  gnt_data;
    logic               legal_push;
    logic               legal_pop;
    rsp_stage_t         new_stage;
    rsp_stage_t         pipe [RD_LAT+1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .advance  (gnt_any),
        .grant    (grant_raw),
        .grant_id (gnt_id)
    );

    // Grants are suppressed combinationally so nothing reaches the stack during reset.
    assign req_grant = rst_n ? grant_raw : '0;
    assign gnt_any   = |req_grant;
    assign gnt_pop   = req_pop[gnt_id];
    assign gnt_data  = req_data[int'(gnt_id)*DATA_W +: DATA_W];

    assign legal_push = gnt_any && !gnt_pop && !stk_full;
    assign legal_pop  = gnt_any &&  gnt_pop && !stk_empty;

    assign stk_wn = legal_push;
    assign stk_rn = legal_pop;
    assign stk_in = legal_push ? gnt_data : '0;

    always_comb begin
        new_stage       = '0;
        new_stage.valid = gnt_any;
        new_stage.id    = ID_W_MAX'(gnt_id);
        new_stage.op    = gnt_pop ? OP_POP : OP_PUSH;
        new_stage.err   = gnt_any && !(legal_push || legal_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (legal_push && occupancy != OCC_W'(DEPTH)) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (legal_pop && occupancy != '0) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

    // Pop data is taken from the stack as the stage leaves the last slot, by
    // which time the stack read latency has elapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= RD_LAT; i++) begin
                pipe[i] <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            pipe[0] <= new_stage;
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            rsp_valid <= pipe[RD_LAT].valid;
            rsp_id    <= pipe[RD_LAT].id[ID_W-1:0];
            rsp_err   <= pipe[RD_LAT].valid && pipe[RD_LAT].err;
            rsp_data  <= (pipe[RD_LAT].valid && pipe[RD_LAT].op == OP_POP && !pipe[RD_LAT].err)
                         ? stk_out : '0;
        end
    end

endmodule
